ntt_batch_wrap: RTL and testbench
=================================

// Module: ntt_batch_wrap
// PURPOSE
// Parametrised successor of the fixed 256 x 16-bit, 4-lane NTT wrap. Buffers one polynomial
// of N coefficients, hands the buffer to an external NTT/INTT core, then streams results out
// LANES coefficients per beat. Uses valid/ready handshakes on both input and output streams.
// Sits between the HPS/bridge data path and the NTT butterfly core on the DE10 design.
// PARAMETERS
// W      16   coefficient width, bits
// N      256  coefficients per polynomial (power of 2)
// LANES  4    coefficients per beat (power of 2, divides N); BEATS=N/LANES, AW=clog2(BEATS)
// PORTS
// clk         in   1        system clock, rising edge
// rst         in   1        asynchronous reset, active-high
// start       in   1        run request; rising edge sampled in IDLE
// mode        in   1        0=NTT, 1=INTT; latched on accepted start
// in_valid    in   1        input beat valid
// in_ready    out  1        input beat accept (LOAD only)
// in_data     in   LANES*W  lane k at [k*W+:W] = coefficient LANES*beat+k
// core_start  out  1        one-cycle pulse on CALC entry
// core_mode   out  1        latched mode
// core_done   in   1        core finished (honoured in CALC only)
// core_addr   in   AW       core buffer beat address
// core_we     in   1        core buffer write enable (CALC only)
// core_wdata  in   LANES*W  core write data
// core_rdata  out  LANES*W  buffer read data, 1 cycle after core_addr
// out_valid   out  1        output beat valid
// out_ready   in   1        output beat accept
// out_data    out  LANES*W  output beat, same lane packing as in_data
// in_done     out  1        sticky: all BEATS loaded
// cal_done    out  1        sticky: core_done seen
// done        out  1        one-cycle pulse after last output beat accepted
// busy        out  1        state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0; buffer contents not cleared.
// - Start trigger = start & ~start_q (start_q registered). Ignored outside IDLE. Holding start high
//   never retriggers.
// - IDLE -> LOAD on trigger: latch mode; clear in_done/cal_done; beat_cnt=0.
// - LOAD: in_ready=1. Each in_valid&in_ready writes buf[beat_cnt], then beat_cnt++.
//   On the beat BEATS-1 handshake: in_done=1 next cycle, go to CALC.
// - CALC: core_start=1 for the first cycle only. Buffer port is owned by the core
//   (core_addr/core_we/core_wdata/core_rdata). core_done -> cal_done=1, go to DRAIN.
//   core_done in the core_start cycle is accepted.
// - DRAIN: sequential synchronous read, 1-cycle RAM latency, then a 2-entry skid/output register.
//   out_data is held stable while out_valid&!out_ready. No beat is dropped or duplicated.
//   Back-to-back beats run at 1 beat/cycle when out_ready is held high.
//   On the beat BEATS-1 handshake: go to DONE.
// - DONE: done=1 for exactly one cycle, then IDLE. in_done and cal_done stay 1 until the next trigger.
// - Outside CALC: core_we ignored, core_rdata=0, core_start=0.
// - Outside LOAD: in_ready=0, in_valid ignored. out_valid=0 except in DRAIN.
// - Counter wrap: beat_cnt is AW bits and wraps to 0 exactly at the phase end.
// - Reset mid-operation: asynchronous return to IDLE; outputs 0 immediately; the partial run is discarded.
// CONFIGURATION
// NTT_WRAP_BITREV_EN defined: DRAIN reads buf[bitrev_AW(beat_cnt)], giving bit-reversed beat order.
//   Lane order inside a beat is unchanged.
// Not defined: DRAIN reads in natural order buf[beat_cnt]. Ports and timing are identical in both builds.
// TESTING
// 1 rst=1 100 ns, then 0 -> all outputs 0, in_ready=0, busy=0. Assert rst mid-DRAIN at beat 20
//   -> out_valid=0 at once; a following full run is correct.
// 2 defaults; load coeff i=4b+k; stub core pulses core_done 10 cycles after core_start, no writes
//   -> 64 output beats equal input in order; done pulses once, 1 cycle after beat 63.
// 3 as 2, with out_ready held low 5 cycles at beat 7 then toggled every cycle
//   -> out_data stable while stalled; 64 unique beats in order.
// 4 mode=1; stub writes buf[a]=~rdata for all a -> core_mode=1; outputs are bitwise-inverted inputs;
//   cal_done=1 from the core_done cycle+1.
// 5 start held high through DONE; extra start pulse during LOAD; in_valid driven in IDLE
//   -> single run only; no writes outside LOAD.
// 6 NTT_WRAP_BITREV_EN defined, stimulus as 2 -> output beat 1 = input beat 32;
//   beat 2 = input beat 16; beat 63 = input beat 63.

Source files
------------

// File: rtl/ntt_batch_wrap_if.sv
// Bus bundle for ntt_batch_wrap: input stream, core buffer port, output stream and status.
// The wrap connects through the slave modport; whoever drives it uses the master modport.
interface ntt_batch_wrap_if #(
    parameter int W     = 16,
    parameter int N     = 256,
    parameter int LANES = 4
);
    localparam int BEATS = N / LANES;
    localparam int AW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                 start;
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic                 core_start;
    logic                 core_mode;
    logic                 core_done;
    logic [AW-1:0]        core_addr;
    logic                 core_we;
    logic [LANES*W-1:0]   core_wdata;
    logic [LANES*W-1:0]   core_rdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_data;
    logic                 in_done;
    logic                 cal_done;
    logic                 done;
    logic                 busy;

    modport slave (
        input  start, mode, in_valid, in_data, core_done, core_addr, core_we, core_wdata, out_ready,
        output in_ready, core_start, core_mode, core_rdata, out_valid, out_data,
               in_done, cal_done, done, busy
    );

    modport master (
        output start, mode, in_valid, in_data, core_done, core_addr, core_we, core_wdata, out_ready,
        input  in_ready, core_start, core_mode, core_rdata, out_valid, out_data,
               in_done, cal_done, done, busy
    );
endinterface

// File: rtl/ntt_batch_wrap.sv
// Polynomial buffer around an external NTT/INTT core: load N coefficients, lend the buffer to
// the core, then drain it LANES per beat. Define NTT_WRAP_BITREV_EN for bit-reversed drain order.
module ntt_batch_wrap #(
    parameter int W     = 16,
    parameter int N     = 256,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst,
    ntt_batch_wrap_if.slave   bus
);
    localparam int BEATS = N / LANES;
    localparam int AW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = LANES * W;
    localparam logic [AW-1:0] LAST = AW'(BEATS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            start_q;
    logic            mode_q, mode_d;
    logic [AW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            rd_end_q, rd_end_d;
    logic            rd_vld_q, rd_vld_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [DW-1:0]   fifo0_q, fifo0_d;
    logic [DW-1:0]   fifo1_q, fifo1_d;
    logic            in_done_q, in_done_d;
    logic            cal_done_q, cal_done_d;
    logic            calc_first_q, calc_first_d;

    logic [DW-1:0]   mem [BEATS];
    logic [DW-1:0]   mem_rd_q;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [AW-1:0]   rd_addr;

    logic            trigger;
    logic            in_fire;
    logic            out_valid;
    logic            out_fire;
    logic            rd_issue;
    logic [2:0]      occ_next;

`ifdef NTT_WRAP_BITREV_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        for (int i = 0; i < AW; i++) bitrev[i] = a[AW-1-i];
    endfunction
    assign rd_addr = bitrev(rd_cnt_q);
`else
    assign rd_addr = rd_cnt_q;
`endif

    assign trigger   = bus.start & ~start_q;
    assign in_fire   = (state_q == S_LOAD) && bus.in_valid;
    assign out_valid = (state_q == S_DRAIN) && (fifo_cnt_q != 2'd0);
    assign out_fire  = out_valid && bus.out_ready;

    // A read may issue only if the skid buffer is sure to have room when its data lands.
    assign occ_next = 3'(fifo_cnt_q) + 3'(rd_vld_q) - 3'(out_fire);
    assign rd_issue = (state_q == S_DRAIN) && !rd_end_q && (occ_next <= 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            mode_q       <= 1'b0;
            beat_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            rd_end_q     <= 1'b0;
            rd_vld_q     <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            fifo0_q      <= '0;
            fifo1_q      <= '0;
            in_done_q    <= 1'b0;
            cal_done_q   <= 1'b0;
            calc_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= bus.start;
            mode_q       <= mode_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_end_q     <= rd_end_d;
            rd_vld_q     <= rd_vld_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo0_q      <= fifo0_d;
            fifo1_q      <= fifo1_d;
            in_done_q    <= in_done_d;
            cal_done_q   <= cal_done_d;
            calc_first_q <= calc_first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger) state_d = S_LOAD;
            S_LOAD:  if (in_fire && beat_cnt_q == LAST) state_d = S_CALC;
            S_CALC:  if (bus.core_done) state_d = S_DRAIN;
            S_DRAIN: if (out_fire && beat_cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mode_d       = mode_q;
        beat_cnt_d   = beat_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_end_d     = rd_end_q;
        rd_vld_d     = 1'b0;
        fifo_cnt_d   = fifo_cnt_q;
        fifo0_d      = fifo0_q;
        fifo1_d      = fifo1_q;
        in_done_d    = in_done_q;
        cal_done_d   = cal_done_q;
        calc_first_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    mode_d     = bus.mode;
                    in_done_d  = 1'b0;
                    cal_done_d = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST) begin
                        in_done_d    = 1'b1;
                        calc_first_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (bus.core_done) begin
                    cal_done_d = 1'b1;
                    rd_cnt_d   = '0;
                    rd_end_d   = 1'b0;
                    fifo_cnt_d = 2'd0;
                end
            end
            S_DRAIN: begin
                rd_vld_d = rd_issue;
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST) rd_end_d = 1'b1;
                end
                if (out_fire) beat_cnt_d = beat_cnt_q + 1'b1;
                // Head entry only moves on a pop, so out_data is frozen while stalled.
                case (fifo_cnt_q)
                    2'd0: begin
                        if (rd_vld_q) begin
                            fifo0_d    = mem_rd_q;
                            fifo_cnt_d = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (rd_vld_q && out_fire) begin
                            fifo0_d = mem_rd_q;
                        end else if (rd_vld_q) begin
                            fifo1_d    = mem_rd_q;
                            fifo_cnt_d = 2'd2;
                        end else if (out_fire) begin
                            fifo_cnt_d = 2'd0;
                        end
                    end
                    default: begin
                        if (out_fire) begin
                            fifo0_d = fifo1_q;
                            if (rd_vld_q) fifo1_d = mem_rd_q;
                            else          fifo_cnt_d = 2'd1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = bus.in_data;
        case (state_q)
            S_LOAD: begin
                mem_addr = beat_cnt_q;
                mem_we   = in_fire;
            end
            S_CALC: begin
                mem_addr  = bus.core_addr;
                mem_we    = bus.core_we;
                mem_wdata = bus.core_wdata;
            end
            S_DRAIN: mem_addr = rd_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rd_q <= mem[mem_addr];
    end

    always_comb begin
        bus.in_ready   = (state_q == S_LOAD);
        bus.core_start = (state_q == S_CALC) && calc_first_q;
        bus.core_mode  = mode_q;
        bus.core_rdata = (state_q == S_CALC) ? mem_rd_q : '0;
        bus.out_valid  = out_valid;
        bus.out_data   = (state_q == S_DRAIN) ? fifo0_q : '0;
        bus.in_done    = in_done_q;
        bus.cal_done   = cal_done_q;
        bus.done       = (state_q == S_DONE);
        bus.busy       = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_ntt_batch_wrap.sv
// Directed bench for ntt_batch_wrap: loads a ramp polynomial, stubs the core, checks the drain.
// Build with NTT_WRAP_BITREV_EN defined to expect bit-reversed beat order.
module tb_ntt_batch_wrap;
    localparam int W     = 16;
    localparam int N     = 256;
    localparam int LANES = 4;
    localparam int BEATS = N / LANES;
    localparam int AW    = 6;
    localparam int DW    = LANES * W;
    localparam logic [DW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ntt_batch_wrap_if #(.W(W), .N(N), .LANES(LANES)) bus ();

    ntt_batch_wrap #(.W(W), .N(N), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] pattern(input int b);
        logic [DW-1:0] p;
        for (int k = 0; k < LANES; k++) p[k*W +: W] = W'(LANES * b + k);
        return p;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int b, input bit inv);
        int s;
`ifdef NTT_WRAP_BITREV_EN
        logic [AW-1:0] a;
        logic [AW-1:0] r;
        a = AW'(b);
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        s = int'(r);
`else
        s = b;
`endif
        return inv ? ~pattern(s) : pattern(s);
    endfunction

    task automatic check_quiet(input string tag);
        check_output({tag, "_flags"}, DW'({bus.busy, bus.in_ready, bus.out_valid, bus.done,
                     bus.in_done, bus.cal_done, bus.core_start, bus.core_mode}), '0);
        check_output({tag, "_out_data"}, bus.out_data, '0);
        check_output({tag, "_core_rdata"}, bus.core_rdata, '0);
    endtask

    task automatic apply_stimulus(input logic m, input bit hold);
        bus.mode  = m;
        bus.start = 1'b1;
        step();
        if (!hold) bus.start = 1'b0;
        check_output("busy_at_load", DW'(bus.busy), 64'd1);
        check_output("in_ready_at_load", DW'(bus.in_ready), 64'd1);
    endtask

    task automatic load_poly(input logic m, input bit glitch, input bit junk);
        int not_ready = 0;
        for (int b = 0; b < BEATS; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pattern(b);
            if (glitch && b == 10) bus.start = 1'b0;
            if (glitch && b == 11) bus.start = 1'b1;
            if (!bus.in_ready) not_ready++;
            step();
        end
        bus.in_valid = junk;
        bus.in_data  = JUNK;
        check_output("load_in_ready_gaps", 64'(not_ready), 64'd0);
        check_output("core_start_on_calc", DW'(bus.core_start), 64'd1);
        check_output("in_done_after_load", DW'(bus.in_done), 64'd1);
        check_output("in_ready_in_calc", DW'(bus.in_ready), 64'd0);
        check_output("core_mode", DW'(bus.core_mode), DW'(m));
    endtask

    task automatic finish_core(input int delay);
        for (int i = 0; i < delay; i++) step();
        bus.core_done = 1'b1;
        check_output("cal_done_before", DW'(bus.cal_done), 64'd0);
        step();
        bus.core_done = 1'b0;
        check_output("cal_done_after", DW'(bus.cal_done), 64'd1);
        check_output("core_start_gone", DW'(bus.core_start), 64'd0);
    endtask

    task automatic invert_core();
        logic [DW-1:0] rd;
        for (int a = 0; a < BEATS; a++) begin
            bus.core_addr = AW'(a);
            bus.core_we   = 1'b0;
            step();
            rd = bus.core_rdata;
            if (a == 0 || a == BEATS - 1)
                check_output($sformatf("core_rdata_%0d", a), rd, pattern(a));
            bus.core_we    = 1'b1;
            bus.core_wdata = ~rd;
            step();
            bus.core_we = 1'b0;
        end
        finish_core(0);
    endtask

    // rmode 0: ready always high; rmode 1: low for 5 cycles at beat 7, then toggling.
    task automatic drain_poly(input bit inv, input int rmode, input int stop_at);
        int got = 0, cyc = 0, first = -1, last = -1, lowcnt = 0, misc = 0;
        bit tog = 1'b1, stalled = 1'b0, rdy;
        logic [DW-1:0] prev = '0;
        while (got < stop_at && cyc < 1000) begin
            if (rmode == 0 || got < 7) rdy = 1'b1;
            else if (lowcnt < 5) begin rdy = 1'b0; lowcnt++; end
            else begin rdy = tog; tog = ~tog; end
            bus.out_ready = rdy;
            if (stalled) begin
                check_output("stall_valid_held", DW'(bus.out_valid), 64'd1);
                check_output("stall_data_held", bus.out_data, prev);
            end
            if (bus.in_ready || bus.core_start || bus.done || bus.core_rdata != '0) misc++;
            if (bus.out_valid && rdy) begin
                check_output($sformatf("beat_%0d", got), bus.out_data, exp_beat(got, inv));
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            stalled = bus.out_valid && !rdy;
            prev    = bus.out_data;
            step();
            cyc++;
        end
        check_output("drain_beat_count", 64'(got), 64'(stop_at));
        check_output("drain_side_signals", 64'(misc), 64'd0);
        if (rmode == 0 && stop_at == BEATS)
            check_output("drain_span_cycles", 64'(last - first + 1), 64'(BEATS));
        if (stop_at == BEATS) begin
            bus.out_ready = 1'b0;
            check_output("done_pulse", DW'({bus.done, bus.busy, bus.out_valid}), 64'b110);
            step();
            check_output("done_cleared", DW'({bus.done, bus.busy}), 64'b00);
            check_output("sticky_flags", DW'({bus.in_done, bus.cal_done}), 64'b11);
        end
    endtask

    initial begin
        int idle_busy;
        bus.start = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.core_done = 1'b0; bus.core_addr = '0; bus.core_we = 1'b0; bus.core_wdata = '0;
        bus.out_ready = 1'b0;

        $display("[TB] reset");
        repeat (10) step();
        rst = 1'b0;
        step();
        check_quiet("reset");

        $display("[TB] natural run, ready held high");
        apply_stimulus(1'b0, 1'b0);
        load_poly(1'b0, 1'b0, 1'b0);
        finish_core(10);
        drain_poly(1'b0, 0, BEATS);

        $display("[TB] run with output back-pressure");
        apply_stimulus(1'b0, 1'b0);
        load_poly(1'b0, 1'b0, 1'b0);
        finish_core(10);
        drain_poly(1'b0, 1, BEATS);

        $display("[TB] INTT run with inverting core");
        apply_stimulus(1'b1, 1'b0);
        load_poly(1'b1, 1'b0, 1'b0);
        invert_core();
        drain_poly(1'b1, 0, BEATS);

        $display("[TB] reset in the middle of the drain");
        apply_stimulus(1'b0, 1'b0);
        load_poly(1'b0, 1'b0, 1'b0);
        finish_core(10);
        drain_poly(1'b0, 0, 20);
        #2 rst = 1'b1;
        #1 check_quiet("mid_reset");
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        step();
        check_quiet("after_mid_reset");

        $display("[TB] full run after mid-drain reset");
        apply_stimulus(1'b0, 1'b0);
        load_poly(1'b0, 1'b0, 1'b0);
        finish_core(10);
        drain_poly(1'b0, 0, BEATS);

        $display("[TB] held start, stray start edge and stray in_valid");
        bus.in_valid = 1'b1;
        bus.in_data  = JUNK;
        repeat (3) step();
        check_output("idle_in_ready", DW'({bus.in_ready, bus.busy}), 64'b00);
        apply_stimulus(1'b0, 1'b1);
        load_poly(1'b0, 1'b1, 1'b1);
        finish_core(0);
        drain_poly(1'b0, 0, BEATS);
        idle_busy = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.busy || bus.in_ready) idle_busy++;
        end
        check_output("no_retrigger", 64'(idle_busy), 64'd0);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
